// File: rtl/blk_mem_arb_pkg.sv
// blk_mem_arb_pkg: shared widths, state encoding and read-pipeline entry type for the
// two-requester block RAM arbiter. The optional zero-fill sweep is controlled by the
// BLK_MEM_ARB_CLEAR_EN macro in blk_mem_arb.sv.
package blk_mem_arb_pkg;

    localparam int unsigned ADDR_W = 8;
    localparam int unsigned DATA_W = 32;
    localparam int unsigned BE_W   = 4;
    localparam int unsigned NREQ   = 2;

    // CLEAR only exists when the zero-fill sweep is compiled in.
    typedef enum logic {
        CLEAR = 1'b0,
        RUN   = 1'b1
    } state_e;

    // One slot of the read-latency tracker: a granted read and who issued it.
    typedef struct packed {
        logic valid;
        logic id;
    } pipe_entry_t;

    // Requester index to one-hot response strobe.
    function automatic logic [NREQ-1:0] id_to_onehot(input logic id);
        return id ? 2'b10 : 2'b01;
    endfunction

endpackage

// File: rtl/blk_mem_arb_if.sv
// blk_mem_arb_if: request/response channels of both requesters plus the RAM port.
// The slave modport is the arbiter's view; the master modport is the environment
// (requesters and the RAM primitive) seen from the other side.
interface blk_mem_arb_if;
    import blk_mem_arb_pkg::*;

    // Requester side, bit/slice i belongs to requester i.
    logic [NREQ-1:0]             req_valid_i;
    logic [NREQ-1:0]             req_ready_o;
    logic [NREQ-1:0][BE_W-1:0]   req_we_i;
    logic [NREQ-1:0][ADDR_W-1:0] req_addr_i;
    logic [NREQ-1:0][DATA_W-1:0] req_wdata_i;
    logic [NREQ-1:0]             rsp_valid_o;
    logic [DATA_W-1:0]           rsp_rdata_o;

    // RAM port A.
    logic                        mem_en_o;
    logic [BE_W-1:0]             mem_we_o;
    logic [ADDR_W-1:0]           mem_addr_o;
    logic [DATA_W-1:0]           mem_din_o;
    logic [DATA_W-1:0]           mem_dout_i;

    modport slave (
        input  req_valid_i,
        input  req_we_i,
        input  req_addr_i,
        input  req_wdata_i,
        input  mem_dout_i,
        output req_ready_o,
        output rsp_valid_o,
        output rsp_rdata_o,
        output mem_en_o,
        output mem_we_o,
        output mem_addr_o,
        output mem_din_o
    );

    modport master (
        output req_valid_i,
        output req_we_i,
        output req_addr_i,
        output req_wdata_i,
        output mem_dout_i,
        input  req_ready_o,
        input  rsp_valid_o,
        input  rsp_rdata_o,
        input  mem_en_o,
        input  mem_we_o,
        input  mem_addr_o,
        input  mem_din_o
    );

endinterface

// File: rtl/blk_mem_arb_rr_arb2.sv
// rr_arb2: two-way round-robin grant. A lone requester always wins; under contention
// the requester that was not granted most recently wins. last_gnt resets to 1 so
// requester 0 wins the first contended cycle.
module rr_arb2 (
    input  logic       clka,
    input  logic       rsta,
    input  logic [1:0] req,
    input  logic       enable,
    output logic [1:0] gnt
);

    logic last_gnt;

    // Combinational grant from the current requests and the previous winner.
    always_comb begin
        gnt = 2'b00;
        if (enable) begin
            case (req)
                2'b01:   gnt = 2'b01;
                2'b10:   gnt = 2'b10;
                2'b11:   gnt = last_gnt ? 2'b01 : 2'b10;
                default: gnt = 2'b00;
            endcase
        end
    end

    // Remember the winner; idle cycles leave the history untouched.
    always_ff @(posedge clka or posedge rsta) begin
        if (rsta) begin
            last_gnt <= 1'b1;
        end else if (|gnt) begin
            last_gnt <= gnt[1];
        end
    end

endmodule

// File: rtl/blk_mem_arb.sv
// blk_mem_arb: shares one single-port 256x32 block RAM between two valid/ready
// requesters. One access per cycle, combinational request-to-RAM path, read data
// returned to the issuer RD_LAT cycles after acceptance.
// Define BLK_MEM_ARB_CLEAR_EN to compile in the post-reset zero-fill sweep.
module blk_mem_arb
    import blk_mem_arb_pkg::*;
#(
    // RAM read latency: 1 (output register off) or 2 (output register on).
    parameter int unsigned RD_LAT = 1
) (
    input  logic          clka,
    input  logic          rsta,
    blk_mem_arb_if.slave  bus
);

    state_e                  state_q;
    logic                    run_en;
    logic [NREQ-1:0]         gnt;
    logic                    gnt_any;
    logic                    gnt_id;
    logic                    gnt_is_read;
    pipe_entry_t [RD_LAT-1:0] pipe_q;
    pipe_entry_t             pipe_tail;

    // Grants are suppressed while reset is held so every output shows the reset state.
    assign run_en = (state_q == RUN) && !rsta;

    rr_arb2 u_rr_arb2 (
        .clka   (clka),
        .rsta   (rsta),
        .req    (bus.req_valid_i),
        .enable (run_en),
        .gnt    (gnt)
    );

    assign gnt_any     = |gnt;
    assign gnt_id      = gnt[1];
    assign gnt_is_read = gnt_any && (bus.req_we_i[gnt_id] == '0);

    assign bus.req_ready_o = gnt;

`ifdef BLK_MEM_ARB_CLEAR_EN
    logic [ADDR_W-1:0] clr_cnt_q;

    // Sweep every address once with zeros, then hand the port to the requesters.
    always_ff @(posedge clka or posedge rsta) begin
        if (rsta) begin
            state_q   <= CLEAR;
            clr_cnt_q <= '0;
        end else if (state_q == CLEAR) begin
            clr_cnt_q <= clr_cnt_q + 1'b1;
            if (clr_cnt_q == '1) begin
                state_q <= RUN;
            end
        end
    end
`else
    // Without the sweep the arbiter is permanently in RUN.
    always_ff @(posedge clka or posedge rsta) begin
        if (rsta) begin
            state_q <= RUN;
        end else begin
            state_q <= RUN;
        end
    end
`endif

    // RAM port mux: granted requester's payload, or the zero-fill sweep.
    always_comb begin
        bus.mem_en_o   = 1'b0;
        bus.mem_we_o   = '0;
        bus.mem_addr_o = '0;
        bus.mem_din_o  = '0;
        if (gnt_any) begin
            bus.mem_en_o   = 1'b1;
            bus.mem_we_o   = bus.req_we_i[gnt_id];
            bus.mem_addr_o = bus.req_addr_i[gnt_id];
            bus.mem_din_o  = bus.req_wdata_i[gnt_id];
        end
`ifdef BLK_MEM_ARB_CLEAR_EN
        // No grant is possible in CLEAR, so this never fights the requester path.
        if (state_q == CLEAR) begin
            bus.mem_en_o   = 1'b1;
            bus.mem_we_o   = '1;
            bus.mem_addr_o = clr_cnt_q;
            bus.mem_din_o  = '0;
        end
`endif
    end

    // Track granted reads through the RAM latency; reset drops anything in flight.
    always_ff @(posedge clka or posedge rsta) begin
        if (rsta) begin
            pipe_q <= '0;
        end else begin
            pipe_q[0].valid <= gnt_is_read;
            pipe_q[0].id    <= gnt_id;
            for (int unsigned i = 1; i < RD_LAT; i++) begin
                pipe_q[i] <= pipe_q[i-1];
            end
        end
    end

    assign pipe_tail = pipe_q[RD_LAT-1];

    // Response strobe and data are qualified by the tail entry; data is zero otherwise.
    always_comb begin
        bus.rsp_valid_o = '0;
        bus.rsp_rdata_o = '0;
        if (pipe_tail.valid) begin
            bus.rsp_valid_o = id_to_onehot(pipe_tail.id);
            bus.rsp_rdata_o = bus.mem_dout_i;
        end
    end

endmodule

// File: tb/tb_blk_mem_arb.sv
// tb_blk_mem_arb: directed bench for blk_mem_arb. Instance a uses RD_LAT=1, instance b
// uses RD_LAT=2; each has its own behavioural RAM. Expectations follow the build's
// BLK_MEM_ARB_CLEAR_EN setting.
module tb_blk_mem_arb;

    logic clka = 1'b0;
    logic rsta = 1'b1;
    int   checks = 0;
    int   errors = 0;

`ifdef BLK_MEM_ARB_CLEAR_EN
    localparam bit Clr = 1'b1;
`else
    localparam bit Clr = 1'b0;
`endif

    always #5 clka = ~clka;

    blk_mem_arb_if bus_a ();
    blk_mem_arb_if bus_b ();

    blk_mem_arb #(.RD_LAT(1)) u_dut_a (.clka(clka), .rsta(rsta), .bus(bus_a.slave));
    blk_mem_arb #(.RD_LAT(2)) u_dut_b (.clka(clka), .rsta(rsta), .bus(bus_b.slave));

    // RAM for instance a, with a backdoor load port used only during reset.
    logic [31:0] ram_a [256];
    logic [31:0] dout_a;
    logic        ld_en = 1'b0;
    logic [7:0]  ld_addr = '0;
    logic [31:0] ld_data = '0;

    always @(posedge clka) begin
        if (ld_en) begin
            ram_a[ld_addr] <= ld_data;
        end else if (bus_a.mem_en_o) begin
            for (int b = 0; b < 4; b++) begin
                if (bus_a.mem_we_o[b]) ram_a[bus_a.mem_addr_o][8*b +: 8] <= bus_a.mem_din_o[8*b +: 8];
            end
            dout_a <= ram_a[bus_a.mem_addr_o];
        end
    end
    assign bus_a.mem_dout_i = dout_a;

    // RAM for instance b with the output register on.
    logic [31:0] ram_b [256];
    logic [31:0] dout_b1, dout_b2;

    always @(posedge clka) begin
        if (bus_b.mem_en_o) begin
            for (int b = 0; b < 4; b++) begin
                if (bus_b.mem_we_o[b]) ram_b[bus_b.mem_addr_o][8*b +: 8] <= bus_b.mem_din_o[8*b +: 8];
            end
            dout_b1 <= ram_b[bus_b.mem_addr_o];
        end
        dout_b2 <= dout_b1;
    end
    assign bus_b.mem_dout_i = dout_b2;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clka);
        #1;
    endtask

    task automatic mid();
        @(negedge clka);
    endtask

    initial begin
        bus_a.req_valid_i = '0;
        bus_a.req_we_i    = '0;
        bus_a.req_addr_i  = '0;
        bus_a.req_wdata_i = '0;
        bus_b.req_valid_i = '0;
        bus_b.req_we_i    = '0;
        bus_b.req_addr_i  = '0;
        bus_b.req_wdata_i = '0;

        // Pre-load RAM a with DEADBEEF while reset is held.
        ld_en   = 1'b1;
        ld_data = 32'hDEADBEEF;
        for (int i = 0; i < 256; i++) begin
            ld_addr = 8'(i);
            tick();
        end
        ld_en = 1'b0;

        // Outputs under reset, with both requesters asking.
        bus_a.req_valid_i = 2'b11;
        mid();
        check("rst_ready",    32'(bus_a.req_ready_o), 32'h0);
        check("rst_rsp",      32'(bus_a.rsp_valid_o), 32'h0);
        check("rst_rdata",    bus_a.rsp_rdata_o,      32'h0);
        check("rst_mem_en",   32'(bus_a.mem_en_o),    Clr ? 32'h1 : 32'h0);
        check("rst_mem_we",   32'(bus_a.mem_we_o),    Clr ? 32'hF : 32'h0);
        check("rst_mem_addr", 32'(bus_a.mem_addr_o),  32'h0);
        check("rst_ready_b",  32'(bus_b.req_ready_o), 32'h0);

        // Release reset with req 0 waiting to read address FF.
        tick();
        bus_a.req_valid_i   = 2'b01;
        bus_a.req_addr_i[0] = 8'hFF;
        rsta = 1'b0;
        if (Clr) begin
            for (int i = 0; i < 256; i++) begin
                mid();
                check("clr_ready", 32'(bus_a.req_ready_o), 32'h0);
                check("clr_addr",  32'(bus_a.mem_addr_o),  32'(i));
                tick();
            end
        end
        mid();
        check("first_ready", 32'(bus_a.req_ready_o), 32'h1);
        check("first_addr",  32'(bus_a.mem_addr_o),  32'hFF);
        tick();
        bus_a.req_valid_i = 2'b00;
        mid();
        check("first_rsp",   32'(bus_a.rsp_valid_o), 32'h1);
        check("first_rdata", bus_a.rsp_rdata_o,      Clr ? 32'h0 : 32'hDEADBEEF);

        // Seed words: 10 <- 1010, 30 <- AAAAAAAA (req 0), 20 <- 2020 (req 1).
        tick();
        bus_a.req_valid_i = 2'b01;
        bus_a.req_we_i[0] = 4'hF;
        bus_a.req_addr_i[0] = 8'h10;
        bus_a.req_wdata_i[0] = 32'h00001010;
        mid();
        check("wr10_ready", 32'(bus_a.req_ready_o), 32'h1);
        check("wr10_we",    32'(bus_a.mem_we_o),    32'hF);
        tick();
        bus_a.req_addr_i[0] = 8'h30;
        bus_a.req_wdata_i[0] = 32'hAAAAAAAA;
        mid();
        check("wr30_din", bus_a.mem_din_o, 32'hAAAAAAAA);
        tick();
        bus_a.req_valid_i = 2'b10;
        bus_a.req_we_i[1] = 4'hF;
        bus_a.req_addr_i[1] = 8'h20;
        bus_a.req_wdata_i[1] = 32'h00002020;
        mid();
        check("wr20_ready", 32'(bus_a.req_ready_o), 32'h2);
        check("wr20_addr",  32'(bus_a.mem_addr_o),  32'h20);
        check("wr20_din",   bus_a.mem_din_o,        32'h00002020);
        tick();

        // Continuous contended reads: grants 0,1,0,1; responses trail by one cycle.
        bus_a.req_valid_i = 2'b11;
        bus_a.req_we_i = '0;
        bus_a.req_addr_i[0] = 8'h10;
        bus_a.req_addr_i[1] = 8'h20;
        mid();
        check("rr0_ready", 32'(bus_a.req_ready_o), 32'h1);
        check("rr0_addr",  32'(bus_a.mem_addr_o),  32'h10);
        tick();
        mid();
        check("rr1_ready", 32'(bus_a.req_ready_o), 32'h2);
        check("rr1_addr",  32'(bus_a.mem_addr_o),  32'h20);
        check("rr1_rsp",   32'(bus_a.rsp_valid_o), 32'h1);
        check("rr1_rdata", bus_a.rsp_rdata_o,      32'h00001010);
        tick();
        mid();
        check("rr2_ready", 32'(bus_a.req_ready_o), 32'h1);
        check("rr2_rsp",   32'(bus_a.rsp_valid_o), 32'h2);
        check("rr2_rdata", bus_a.rsp_rdata_o,      32'h00002020);
        tick();
        mid();
        check("rr3_ready", 32'(bus_a.req_ready_o), 32'h2);
        check("rr3_rsp",   32'(bus_a.rsp_valid_o), 32'h1);
        check("rr3_rdata", bus_a.rsp_rdata_o,      32'h00001010);
        tick();
        bus_a.req_valid_i = 2'b00;
        mid();
        check("rr4_ready",  32'(bus_a.req_ready_o), 32'h0);
        check("rr4_mem_en", 32'(bus_a.mem_en_o),    32'h0);
        check("rr4_rsp",    32'(bus_a.rsp_valid_o), 32'h2);
        check("rr4_rdata",  bus_a.rsp_rdata_o,      32'h00002020);
        tick();

        // Byte write by req 0 into AAAAAAAA, then read back by req 1.
        bus_a.req_valid_i = 2'b01;
        bus_a.req_we_i[0] = 4'b0101;
        bus_a.req_addr_i[0] = 8'h30;
        bus_a.req_wdata_i[0] = 32'h11223344;
        mid();
        check("bw_we",  32'(bus_a.mem_we_o), 32'h5);
        check("bw_din", bus_a.mem_din_o,     32'h11223344);
        tick();
        bus_a.req_valid_i = 2'b10;
        bus_a.req_we_i[1] = 4'h0;
        bus_a.req_addr_i[1] = 8'h30;
        mid();
        check("bw_rd_ready", 32'(bus_a.req_ready_o), 32'h2);
        tick();
        bus_a.req_valid_i = 2'b00;
        mid();
        check("bw_rsp",   32'(bus_a.rsp_valid_o), 32'h2);
        check("bw_rdata", bus_a.rsp_rdata_o,      32'hAA22AA44);
        tick();

        // Req 1 alone and held; req 0 idle with a different payload on its lines.
        bus_a.req_valid_i = 2'b10;
        bus_a.req_we_i[0] = 4'h0;
        bus_a.req_addr_i[0] = 8'h55;
        bus_a.req_wdata_i[0] = 32'h55555555;
        bus_a.req_we_i[1] = 4'hF;
        bus_a.req_addr_i[1] = 8'h40;
        bus_a.req_wdata_i[1] = 32'h12345678;
        for (int k = 0; k < 3; k++) begin
            mid();
            check("hold_ready", 32'(bus_a.req_ready_o), 32'h2);
            check("hold_addr",  32'(bus_a.mem_addr_o),  32'h40);
            check("hold_din",   bus_a.mem_din_o,        32'h12345678);
            tick();
        end
        bus_a.req_valid_i = 2'b00;

        // Read by req 0 granted, then reset one cycle later: the response must vanish.
        bus_a.req_we_i = '0;
        bus_a.req_addr_i[0] = 8'h10;
        bus_a.req_addr_i[1] = 8'h20;
        bus_a.req_valid_i = 2'b01;
        mid();
        check("mr_ready", 32'(bus_a.req_ready_o), 32'h1);
        tick();
        rsta = 1'b1;
        bus_a.req_valid_i = 2'b11;
        mid();
        check("mr_rsp",   32'(bus_a.rsp_valid_o), 32'h0);
        check("mr_rdata", bus_a.rsp_rdata_o,      32'h0);
        check("mr_ready_rst", 32'(bus_a.req_ready_o), 32'h0);
        tick();
        rsta = 1'b0;
        mid();
        check("mr_rsp_post", 32'(bus_a.rsp_valid_o), 32'h0);
        if (Clr) begin
            for (int i = 0; i < 256; i++) tick();
            mid();
        end
        check("mr_ready_first", 32'(bus_a.req_ready_o), 32'h1);
        tick();
        bus_a.req_valid_i = 2'b00;
        mid();
        check("mr_rsp_first", 32'(bus_a.rsp_valid_o), 32'h1);
        check("mr_rdata_first", bus_a.rsp_rdata_o,    Clr ? 32'h0 : 32'h00001010);
        tick();

        // Instance b (RD_LAT=2): seed 1..3 then three back-to-back reads by req 1.
        for (int k = 0; k < 3; k++) begin
            bus_b.req_valid_i = 2'b10;
            bus_b.req_we_i[1] = 4'hF;
            bus_b.req_addr_i[1] = 8'(k + 1);
            bus_b.req_wdata_i[1] = 32'hB1 + 32'(k);
            mid();
            check("l2_wr_ready", 32'(bus_b.req_ready_o), 32'h2);
            tick();
        end
        bus_b.req_we_i[1] = 4'h0;
        bus_b.req_addr_i[1] = 8'h01;
        mid();
        check("l2_t0_ready", 32'(bus_b.req_ready_o), 32'h2);
        tick();
        bus_b.req_addr_i[1] = 8'h02;
        mid();
        check("l2_t1_rsp", 32'(bus_b.rsp_valid_o), 32'h0);
        tick();
        bus_b.req_addr_i[1] = 8'h03;
        mid();
        check("l2_t2_rsp",   32'(bus_b.rsp_valid_o), 32'h2);
        check("l2_t2_rdata", bus_b.rsp_rdata_o,      32'hB1);
        tick();
        bus_b.req_valid_i = 2'b00;
        mid();
        check("l2_t3_rsp",   32'(bus_b.rsp_valid_o), 32'h2);
        check("l2_t3_rdata", bus_b.rsp_rdata_o,      32'hB2);
        tick();
        mid();
        check("l2_t4_rsp",   32'(bus_b.rsp_valid_o), 32'h2);
        check("l2_t4_rdata", bus_b.rsp_rdata_o,      32'hB3);
        tick();
        mid();
        check("l2_t5_rsp",   32'(bus_b.rsp_valid_o), 32'h0);
        check("l2_t5_rdata", bus_b.rsp_rdata_o,      32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/blk_mem_arb.md
# blk_mem_arb

Two-requester arbiter and sequencer for the 256 x 32 single-port block RAM (byte write enables) used in the SoC memory subsystem. It shares the one RAM port between two masters on a valid/ready request channel, issues at most one access per cycle, and returns read data to the issuing master after the fixed RAM read latency. An optional post-reset sweep zero-fills the whole RAM before any request is accepted.

## Interface
- RD_LAT, 1: RAM read latency in cycles; 1 = primitive output register off, 2 = on. Legal values are 1 and 2 only.
- clka  in  1  clock, shared with the RAM clka
- rsta  in  1  asynchronous reset, active-high
- req_valid_i  in  2  request valid, bit i = requester i
- req_ready_o  out  2  request accepted this cycle
- req_we_i  in  2x4  byte write enables; 0 = read
- req_addr_i  in  2x8  word address
- req_wdata_i  in  2x32  write data
- rsp_valid_o  out  2  read data valid for requester i
- rsp_rdata_o  out  32  read data; 0 when no rsp_valid_o bit is set
- mem_en_o  out  1  to RAM ena
- mem_we_o  out  4  to RAM wea
- mem_addr_o  out  8  to RAM addra
- mem_din_o  out  32  to RAM dina
- mem_dout_i  in  32  from RAM douta

## Operation
- States are CLEAR and RUN. Reset enters CLEAR when BLK_MEM_ARB_CLEAR_EN is defined, otherwise RUN.
- CLEAR:
  - 8-bit clr_cnt drives mem_addr_o; mem_en_o=1, mem_we_o=4'hF, mem_din_o=0, req_ready_o=0.
  - clr_cnt increments every cycle; after address 255 is written, the state goes to RUN. The sweep is exactly 256 cycles.
- RUN, round-robin: a last_gnt register holds the requester granted most recently, reset value 1.
  - Only one requester valid: that requester is granted.
  - Both valid: the requester that is not last_gnt is granted.
  - last_gnt updates only on a grant.
- Grant:
  - req_ready_o[g]=1 in the same cycle (combinational from req_valid_i and state).
  - mem_en_o=1 and mem_we/addr/din are muxed from requester g.
  - With no request: mem_en_o=0, mem_we_o=0, and addr/din hold 0.
- Requesters hold valid and payload stable until ready is asserted. The arbiter never grants a requester whose valid is low.
- Read tracking:
  - An RD_LAT-deep shift register of {valid, id} records granted reads (req_we==0).
  - At the tail, rsp_valid_o[id]=1 for one cycle and rsp_rdata_o=mem_dout_i.
  - Writes produce no response.
- Back-to-back reads from either or both requesters return in issue order, one per cycle, with no bubbles.
- Reset asserted mid-operation:
  - State and counters are reset and the shift register is flushed; in-flight responses are dropped.
  - last_gnt returns to 1.

## Timing
- Output values while rsta is asserted:
  - req_ready_o=0, rsp_valid_o=0, rsp_rdata_o=0.
  - mem_* outputs follow the reset state: CLEAR gives en=1, we=F, addr=0, din=0; RUN gives all 0.
- Request to RAM: 0 cycles, combinational path from req_* to mem_*.
- Read response: rsp_valid_o is asserted RD_LAT cycles after the accepting clka edge.
- Throughput: 1 access/cycle. Under contention, each requester gets at least 1 grant in every 2 cycles.
- The first grant can occur on the cycle after CLEAR ends (with the macro), or on the first cycle after reset release (without it).

## Configuration
- BLK_MEM_ARB_CLEAR_EN:
  - Defined: the CLEAR state and clr_cnt are compiled in, and the RAM is all-zero before the first grant.
  - Undefined: the state register is reset to RUN, clr_cnt is absent, and RAM contents are whatever the init file left.

## Structure
- Package blk_mem_arb_pkg holds:
  - ADDR_W=8, DATA_W=32, BE_W=4, NREQ=2.
  - The state enum {CLEAR, RUN}.
  - The pipeline entry typedef {valid, id}.
- Sub-module rr_arb2: 2-way round-robin grant logic holding last_gnt. Inputs are req[1:0] and enable; outputs are gnt[1:0].
- The RAM primitive is instantiated by the parent alongside this block, not inside it.

## Test plan
- Reset with CLEAR_EN defined:
  - Stimulus: pre-load the RAM with 32'hDEADBEEF, then release reset.
  - Response: req_ready_o=0 for 256 cycles; then a read of addr 8'hFF returns 0 after RD_LAT cycles.
- Both requesters reading continuously (req 0 at addr 8'h10, req 1 at addr 8'h20):
  - Grants alternate 0,1,0,1 starting with 0.
  - rsp_valid_o alternates with matching data, one response per cycle.
- Byte write then read:
  - Stimulus: req 0 writes we=4'b0101, data 32'h11223344 to a word holding 32'hAAAAAAAA; req 1 then reads it.
  - Response: 32'hAA22AA44.
- RD_LAT=2:
  - Stimulus: three back-to-back reads by req 1.
  - Response: rsp_valid_o[1] is high on cycles +2, +3, +4 with data in order.
- Reset mid-stream:
  - Stimulus: assert rsta one cycle after a read is granted.
  - Response: no rsp_valid_o pulse; after release, the first grant under contention goes to req 0.
- Single valid with holding:
  - Stimulus: req 1 is the only one valid and stays valid with req 0 idle.
  - Response: req_ready_o[1]=1 every cycle; the payload passes to mem_* the same cycle.
